// File: rtl/stream_element_packer.sv
// -----------------------------------------------------------------------------
// stream_element_packer
//
// Packs variable-length elements (0..MAX_ELEMENT_BYTES bytes each) into a
// dense stream of DATA_BUS_WIDTH_BYTES-wide beats. Bytes are kept in arrival
// order with no gaps between elements. A flush request drains any partial
// beat with a reduced keep mask and marks it with data_last.
//
// Ports
//   clk            : clock, all state changes on the rising edge
//   reset          : asynchronous, active-low reset
//   element_in     : element bytes, byte k on bits [8k+7:8k], byte 0 first
//   element_len    : number of valid bytes in element_in (clamped to M)
//   element_valid  : element offered
//   element_ready  : element accepted this cycle
//   flush          : single-cycle request to drain the partial beat
//   data_out       : packed beat, lane 0 holds the oldest byte
//   data_keep      : per-lane valid mask for data_out
//   data_last      : final beat of a flush
//   data_valid     : beat offered
//   data_ready     : downstream accepts the beat
//   flush_done     : one-cycle pulse when a flush completes
//   len_error      : sticky, an over-long element_len was accepted
//   beat_count     : number of transferred beats, wraps modulo 2^16
// -----------------------------------------------------------------------------
module stream_element_packer #(
  parameter int DATA_BUS_WIDTH_BYTES = 8,
  parameter int MAX_ELEMENT_BYTES    = 38,
  parameter int LEN_WIDTH            = 6
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [MAX_ELEMENT_BYTES*8-1:0]      element_in,
  input  logic [LEN_WIDTH-1:0]                element_len,
  input  logic                                element_valid,
  output logic                                element_ready,
  input  logic                                flush,
  output logic [DATA_BUS_WIDTH_BYTES*8-1:0]   data_out,
  output logic [DATA_BUS_WIDTH_BYTES-1:0]     data_keep,
  output logic                                data_last,
  output logic                                data_valid,
  input  logic                                data_ready,
  output logic                                flush_done,
  output logic                                len_error,
  output logic [15:0]                         beat_count
);

  localparam int B      = DATA_BUS_WIDTH_BYTES;
  localparam int M      = MAX_ELEMENT_BYTES;
  // An element is only accepted while fewer than B bytes are buffered, so
  // the buffer never needs more than (B-1) + M bytes.
  localparam int CAP    = M + B - 1;
  localparam int BUF_W  = CAP * 8;
  localparam int ELEM_W = M * 8;
  localparam int FILL_W = $clog2(CAP + 1);

  localparam logic [FILL_W-1:0] B_FILL = FILL_W'(B);

  typedef enum logic {
    S_FILL  = 1'b0,
    S_FLUSH = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q,       state_d;
  logic [FILL_W-1:0]  fill_q,        fill_d;
  logic [BUF_W-1:0]   buf_q,         buf_d;
  logic [B-1:0]       keep_q,        keep_d;
  logic               last_q,        last_d;
  logic               ready_en_q,    ready_en_d;
  logic               len_error_q,   len_error_d;
  logic [15:0]        beat_count_q,  beat_count_d;

  // ---------------------------------------------------------------------------
  // Handshakes (registers only, so no loop through the transfer logic)
  // ---------------------------------------------------------------------------
  logic elem_xfer;
  logic beat_xfer;

  // ready_en_q holds element_ready low through reset and releases it on the
  // first clock edge after reset is removed.
  assign element_ready = ready_en_q && (state_q == S_FILL) && (fill_q < B_FILL);
  assign data_valid    = (state_q == S_FILL) ? (fill_q >= B_FILL)
                                             : (fill_q != '0);

  assign elem_xfer = element_valid & element_ready;
  assign beat_xfer = data_valid & data_ready;

  // ---------------------------------------------------------------------------
  // Datapath: remove the outgoing beat, then append the accepted element
  // ---------------------------------------------------------------------------
  logic                 len_over;
  logic [LEN_WIDTH-1:0] len_eff;
  logic [FILL_W-1:0]    remove_cnt;
  logic [FILL_W-1:0]    kept_cnt;
  logic [ELEM_W-1:0]    elem_masked;
  logic [BUF_W-1:0]     buf_shift;

  // NOTE: every signal assigned in an always_comb gets a default at the top
  // of the block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    len_over    = 1'b0;
    len_eff     = element_len;
    remove_cnt  = '0;
    kept_cnt    = fill_q;
    elem_masked = '0;
    buf_shift   = buf_q;
    buf_d       = buf_q;
    fill_d      = fill_q;

    len_over = int'(element_len) > M;
    if (len_over) begin
      len_eff = LEN_WIDTH'(M);
    end

    // A full beat removes B bytes; the last beat of a flush removes what is
    // left, which may be fewer than B.
    if (beat_xfer) begin
      remove_cnt = (fill_q > B_FILL) ? B_FILL : fill_q;
    end
    kept_cnt = fill_q - remove_cnt;

    // Bytes past len_eff are zeroed so the buffer stays zero above fill.
    // That keeps the unused lanes of a partial beat at zero for free.
    for (int k = 0; k < M; k++) begin
      if (k < int'(len_eff)) begin
        elem_masked[8*k +: 8] = element_in[8*k +: 8];
      end
    end

    buf_shift = buf_q >> {remove_cnt, 3'b000};

    if (elem_xfer) begin
      buf_d  = buf_shift | (BUF_W'(elem_masked) << {kept_cnt, 3'b000});
      fill_d = kept_cnt + FILL_W'(len_eff);
    end else begin
      buf_d  = buf_shift;
      fill_d = kept_cnt;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: FILL collects elements, FLUSH drains the remainder
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;

    unique case (state_q)
      S_FILL: begin
        if (flush) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Either nothing was buffered on entry, or the beat carrying
        // data_last is leaving this cycle.
        if (fill_q == '0) begin
          state_d    = S_FILL;
          flush_done = 1'b1;
        end else if (beat_xfer && (fill_q <= B_FILL)) begin
          state_d    = S_FILL;
          flush_done = 1'b1;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Beat qualifiers and status, computed for the next cycle so that the
  // outputs come straight from flops
  // ---------------------------------------------------------------------------
  always_comb begin
    keep_d       = '1;
    last_d       = 1'b0;
    ready_en_d   = 1'b1;
    len_error_d  = len_error_q | (elem_xfer & len_over);
    beat_count_d = beat_count_q + (beat_xfer ? 16'd1 : 16'd0);

    if ((state_d == S_FLUSH) && (fill_d <= B_FILL)) begin
      last_d = 1'b1;
      for (int i = 0; i < B; i++) begin
        keep_d[i] = (FILL_W'(i) < fill_d);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the values from before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FILL;
      fill_q       <= '0;
      // NOTE: the byte buffer is reset like any other flop because its low
      // lanes are data_out, which must read zero during reset and must not
      // leak stale bytes into the first beat afterwards.
      buf_q        <= '0;
      keep_q       <= '0;
      last_q       <= 1'b0;
      ready_en_q   <= 1'b0;
      len_error_q  <= 1'b0;
      beat_count_q <= '0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      buf_q        <= buf_d;
      keep_q       <= keep_d;
      last_q       <= last_d;
      ready_en_q   <= ready_en_d;
      len_error_q  <= len_error_d;
      beat_count_q <= beat_count_d;
    end
  end

  // The oldest B buffered bytes are the beat.
  assign data_out   = buf_q[B*8-1:0];
  assign data_keep  = keep_q;
  assign data_last  = last_q;
  assign len_error  = len_error_q;
  assign beat_count = beat_count_q;

endmodule

// File: doc/stream_element_packer.md
STREAM_ELEMENT_PACKER -- requirements
Module: stream_element_packer

Interface
REQ-001 Parameter DATA_BUS_WIDTH_BYTES, default 8: output beat width in bytes (B).
REQ-002 Parameter MAX_ELEMENT_BYTES, default 38: largest element accepted (M).
REQ-003 Parameter LEN_WIDTH, default 6: width of the element length field.
REQ-004 Port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port element_in, input, M*8: element bytes; byte k is on bits [8k+7:8k], and byte 0 is the first on the wire.
REQ-007 Port element_len, input, LEN_WIDTH: number of valid bytes in element_in.
REQ-008 Port element_valid, input, 1: the element on element_in/element_len is offered.
REQ-009 Port element_ready, output, 1: the packer accepts the element this cycle.
REQ-010 Port flush, input, 1: single-cycle request to drain any partial beat.
REQ-011 Port data_out, output, B*8: packed beat; lane 0 (bits [7:0]) is the oldest byte.
REQ-012 Port data_keep, output, B: per-lane valid mask for data_out.
REQ-013 Port data_last, output, 1: marks the final beat of a flush.
REQ-014 Port data_valid, output, 1: a beat is offered.
REQ-015 Port data_ready, input, 1: downstream accepts the beat.
REQ-016 Port flush_done, output, 1: one-cycle pulse when a flush completes.
REQ-017 Port len_error, output, 1: sticky flag, set when an element_len greater than M is accepted.
REQ-018 Port beat_count, output, 16: count of transferred beats; wraps modulo 2^16.

Function
REQ-019 The packer SHALL hold a byte buffer of capacity M+B-1 and a fill count in the range 0..M+B-1.
REQ-020 An element transfer occurs when element_valid and element_ready are both high.
REQ-021 A beat transfer occurs when data_valid and data_ready are both high.
REQ-022 element_ready SHALL be 1 only when state is FILL and fill < B.
REQ-023 On an element transfer, the packer SHALL append element_len bytes in order directly behind the buffered bytes, with no gaps.
REQ-024 An element_len of 0 SHALL be accepted and append nothing.
REQ-025 An element_len greater than M SHALL be clamped to M, and len_error SHALL be set.
REQ-026 In FILL state, data_valid SHALL be (fill >= B); data_keep SHALL be all ones; data_last SHALL be 0.
REQ-027 data_out SHALL present the oldest B buffered bytes and SHALL be driven directly from registers, with no combinational path from any input.
REQ-028 A beat transfer SHALL remove B bytes (or fewer, see REQ-031) and shift the remaining bytes down.
REQ-029 A beat transfer and an element transfer in the same cycle SHALL both occur: new fill = fill - removed + len, and the appended bytes follow the remaining bytes.
REQ-030 Latency: an element accepted at cycle N contributes to data_out from cycle N+1.
REQ-031 State machine, states FILL and FLUSH:
- FILL -> FLUSH when flush=1 is sampled in FILL. An element transfer in that same cycle is still taken.
- In FLUSH, element_ready=0 and data_valid=(fill>0).
- In FLUSH, a beat with fill <= B SHALL have data_keep = lower fill bits set, data_last=1, unused lanes driven 0.
- A beat with fill > B SHALL be a full beat with data_last=0.
- FLUSH -> FILL on the transfer of the data_last beat, with flush_done=1 in that cycle.
- If fill=0 on entry to FLUSH: no beat is emitted, and the FSM returns to FILL in the next cycle with flush_done=1.
REQ-032 flush sampled while in FLUSH SHALL be ignored.
REQ-033 While data_valid=1 and data_ready=0, data_out, data_keep and data_last SHALL remain stable.
REQ-034 beat_count SHALL increment by 1 on every beat transfer, including partial beats.

Reset
REQ-035 While reset=0, and immediately on its assertion, the packer SHALL force: fill=0, state=FILL, element_ready=0, data_valid=0, data_keep=0, data_last=0, data_out=0, flush_done=0, len_error=0, beat_count=0.
REQ-036 Reset asserted mid-element or mid-flush SHALL discard all buffered bytes; no partial beat is emitted afterwards.
REQ-037 element_ready SHALL first go to 1 in the first cycle after reset is released.

Verification
REQ-038 Elements of length 27 then 21, with bytes 0x00..0x1A then 0x20..0x34, and data_ready=1 -> six full beats; beat 3 = 0x18,0x19,0x1A,0x20,0x21,0x22,0x23,0x24; beat_count=6; fill=0.
REQ-039 One element of length 19, then flush -> two full beats, then a beat with data_keep=0x07, data_last=1 and lanes 3..7 = 0; flush_done pulses once.
REQ-040 flush with an empty buffer -> no beat emitted; flush_done=1 one cycle later; element_ready returns to 1.
REQ-041 Length-33 element with data_ready held 0 for 5 cycles -> data_out stable and element_ready=0 throughout; the same 4 full beats are delivered after release.
REQ-042 element_len=40 -> 38 bytes packed, len_error=1 and stays 1 until reset.
REQ-043 reset asserted with fill=13 -> all outputs zero asynchronously; after release, the first beat contains only newly sent bytes.
